rand_server: RTL and testbench

// Shares one free-running 8-bit random source among several game requesters,
// e.g. obstacle spawner, gap length and coin placement. Each requester asks for a

---
 rtl/rand_server.sv | 156 +++++++++++++++
 tb/tb_rand_server.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rand_server.sv
// Round-robin server sharing one 8-bit random source among NUM_REQ requesters.
// Each grant returns a value in [0, bound] via mask-and-reject with a bounded fallback.
module rand_server #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [7:0]             rnd_in,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [8*NUM_REQ-1:0]   bound_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic [7:0]             value_out,
    output logic                   busy_out
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [7:0]           bound_q, bound_d;
    logic [7:0]           mask_q, mask_d;
    logic [3:0]           tries_q, tries_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [7:0]           value_q, value_d;
    logic                 busy_q, busy_d;

    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        pick_bound_sel;
    logic [7:0]           cand;
    int                   cand_pos;

    // Smallest all-ones mask covering the bound: smear the top set bit downwards.
    function automatic logic [7:0] cover_mask(input logic [7:0] b);
        logic [7:0] m;
        m = b | (b >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IW-1:0] i);
        logic [NUM_REQ-1:0] v;
        v = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return v << i;
    endfunction

    assign cand           = rnd_in & mask_q;
    assign pick_bound_sel = pick_idx;

    // Round-robin pick: scan farthest-to-nearest after rr_q so the nearest request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_pos   = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_pos = int'(rr_q) + off;
            cand_pos = (cand_pos >= NUM_REQ) ? cand_pos - NUM_REQ : cand_pos;
            if (req_in[IW'(cand_pos)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand_pos);
            end else begin
                pick_found = pick_found;
            end
        end
    end

    // Next-state and output computation for the serve FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        bound_d = bound_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        grant_d = '0;
        value_d = value_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SAMPLE;
                    idx_d   = pick_idx;
                    bound_d = bound_in[{pick_bound_sel, 3'b000} +: 8];
                    mask_d  = cover_mask(bound_in[{pick_bound_sel, 3'b000} +: 8]);
                    tries_d = 4'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                if (cand <= bound_q) begin
                    value_d = cand;
                    grant_d = one_hot(idx_q);
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (tries_q == 4'(MAX_TRIES - 1)) begin
                    // cand lies in (bound, 2*bound+1], so this lands in [0, bound]
                    value_d = cand - bound_q - 8'd1;
                    grant_d = one_hot(idx_q);
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
            end
            DONE: begin
                rr_d    = idx_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            bound_q <= 8'd0;
            mask_q  <= 8'd0;
            tries_q <= 4'd0;
            grant_q <= '0;
            value_q <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            bound_q <= bound_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
            grant_q <= grant_d;
            value_q <= value_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_out = grant_q;
    assign value_out = value_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_rand_server.sv
// Bench for rand_server: directed vector table, hand-written corner sequences,
// and randomized serves checked against a transaction-level reference model.
module tb_rand_server;

    localparam int NR = 4;
    localparam int MT = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  rnd_in;
    logic [3:0]  req_in;
    logic [31:0] bound_in;
    logic [3:0]  grant_out;
    logic [7:0]  value_out;
    logic        busy_out;

    int          total = 0;
    int          bad   = 0;
    int          last;
    logic [7:0]  bnd[4];
    logic [7:0]  rnd_seq[16];

    typedef struct {
        string       nm;
        logic [3:0]  req;
        logic [31:0] bounds;
        logic [7:0]  r1, r2, r3;
        int          exp_idx;
        logic [7:0]  exp_val;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    always #5 clk_in = ~clk_in;

    rand_server #(.NUM_REQ(NR), .MAX_TRIES(MT)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rnd_in   (rnd_in),
        .req_in   (req_in),
        .bound_in (bound_in),
        .grant_out(grant_out),
        .value_out(value_out),
        .busy_out (busy_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_bounds();
        bound_in = {bnd[3], bnd[2], bnd[1], bnd[0]};
    endtask

    task automatic fill_rnd(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
        rnd_seq[0] = r1;
        rnd_seq[1] = r1;
        rnd_seq[2] = r2;
        for (int i = 3; i < 16; i++) rnd_seq[i] = r3;
    endtask

    // Reference: pick next requester after the last grant, then take the first
    // in-range masked sample, or the wrapped last sample if none fits.
    task automatic predict(input logic [3:0] reqs, output int idx, output logic [7:0] val,
                           output int cyc);
        int b;
        int m;
        int v;
        idx = 0;
        for (int k = NR; k >= 1; k--) begin
            int i;
            i = (last + k) % NR;
            if (reqs[i]) idx = i;
        end
        b = int'(bnd[idx]);
        m = 0;
        while (m < b) m = m * 2 + 1;
        v   = int'(rnd_seq[MT]) & m;
        val = 8'(v - b - 1);
        cyc = MT + 1;
        for (int s = MT - 1; s >= 0; s--) begin
            v = int'(rnd_seq[1 + s]) & m;
            if (v <= b) begin
                val = 8'(v);
                cyc = s + 2;
            end
        end
    endtask

    // Caller must be sitting in an IDLE cycle with req_in/bound_in driven (cycle 0).
    // Returns one cycle after the grant, i.e. in the next IDLE cycle.
    task automatic run_serve(input string nm, input int exp_idx, input logic [7:0] exp_val,
                             input int exp_cyc, input bit scramble);
        bit got     = 1'b0;
        bit busy_ok = 1'b1;
        int cyc     = 0;
        chk({nm, "_idle_busy"}, 32'(busy_out), 32'd0);
        rnd_in = rnd_seq[0];
        while (!got && cyc < MT + 4) begin
            step();
            cyc++;
            if (grant_out != 4'b0000) begin
                got = 1'b1;
                chk({nm, "_grant"}, 32'(grant_out), 32'(4'b0001 << exp_idx));
                chk({nm, "_value"}, 32'(value_out), 32'(exp_val));
                chk({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
                chk({nm, "_busy_at_grant"}, 32'(busy_out), 32'd0);
            end else if (busy_out !== 1'b1) begin
                busy_ok = 1'b0;
            end else begin
                busy_ok = busy_ok;
            end
            rnd_in = rnd_seq[cyc];
            if (scramble) begin
                req_in   = 4'($urandom);
                bound_in = $urandom;
            end
        end
        if (!got) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_busy_during"}, 32'(busy_ok), 32'd1);
            step();
        end
        last = exp_idx;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        req_in = 4'b0000;
        step();
        step();
        rst_in = 1'b0;
        last   = NR - 1;
    endtask

    initial begin
        int          order[5];
        int          p_idx;
        int          p_cyc;
        logic [7:0]  p_val;

        vecs[0] = '{"t1_accept",   4'b0001, 32'h0000_0005, 8'h03, 8'h03, 8'h03, 0, 8'h03, 2};
        vecs[1] = '{"t2_reject",   4'b0001, 32'h0000_0005, 8'h06, 8'h07, 8'h02, 0, 8'h02, 4};
        vecs[2] = '{"t3_fallback", 4'b0001, 32'h0000_0004, 8'h07, 8'h07, 8'h07, 0, 8'h02, 9};
        vecs[3] = '{"t5_bound0",   4'b0100, 32'h0000_0000, 8'hFF, 8'hFF, 8'hFF, 2, 8'h00, 2};
        vecs[4] = '{"t5_bound255", 4'b1000, 32'hFF00_0000, 8'hFF, 8'hFF, 8'hFF, 3, 8'hFF, 2};
        vecs[5] = '{"mask3_rej",   4'b0010, 32'h0000_0200, 8'h07, 8'h03, 8'h06, 1, 8'h02, 4};
        vecs[6] = '{"rr_all",      4'b1111, 32'hC8C8_C8C8, 8'hC9, 8'h10, 8'h10, 2, 8'h10, 3};
        vecs[7] = '{"rr_wrap",     4'b1010, 32'h0100_0000, 8'h01, 8'h01, 8'h01, 3, 8'h01, 2};

        rst_in   = 1'b1;
        rnd_in   = 8'h00;
        req_in   = 4'b0000;
        bound_in = 32'h0;
        do_reset();
        chk("reset_grant", 32'(grant_out), 32'd0);
        chk("reset_value", 32'(value_out), 32'd0);
        chk("reset_busy",  32'(busy_out),  32'd0);

        for (int k = 0; k < 8; k++) begin
            req_in   = vecs[k].req;
            bound_in = vecs[k].bounds;
            fill_rnd(vecs[k].r1, vecs[k].r2, vecs[k].r3);
            run_serve(vecs[k].nm, vecs[k].exp_idx, vecs[k].exp_val, vecs[k].exp_cyc, 1'b0);
        end

        // Held requests from everyone rotate 0,1,2,3,0 with minimum spacing.
        do_reset();
        order = '{0, 1, 2, 3, 0};
        req_in = 4'b1111;
        for (int i = 0; i < 4; i++) bnd[i] = 8'hFF;
        drive_bounds();
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 16; i++) rnd_seq[i] = 8'($urandom);
            rnd_seq[1] = 8'($urandom_range(1, 255));
            run_serve($sformatf("t4_rot%0d", g), order[g], rnd_seq[1], 2, 1'b0);
        end

        // Reset while sampling aborts the serve, then req 0 regains first priority.
        req_in = 4'b0001;
        bnd[0] = 8'd4;
        drive_bounds();
        rnd_in = 8'h07;
        step();
        chk("t6_busy_sample", 32'(busy_out), 32'd1);
        step();
        rst_in = 1'b1;
        step();
        chk("t6_rst_grant", 32'(grant_out), 32'd0);
        chk("t6_rst_value", 32'(value_out), 32'd0);
        chk("t6_rst_busy",  32'(busy_out),  32'd0);
        rst_in = 1'b0;
        last   = NR - 1;
        req_in = 4'b1111;
        for (int i = 0; i < 4; i++) bnd[i] = 8'hFF;
        drive_bounds();
        fill_rnd(8'h5A, 8'h5A, 8'h5A);
        run_serve("t6_after_rst", 0, 8'h5A, 2, 1'b0);

        // Randomized serves; inputs are scrambled mid-serve and must be ignored.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       bnd[i] = 8'($urandom_range(0, 3));
                    1:       bnd[i] = 8'($urandom_range(0, 255));
                    2:       bnd[i] = 8'hFF;
                    default: bnd[i] = 8'($urandom_range(64, 130));
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                rnd_seq[0] = 8'($urandom);
                for (int i = 1; i < 16; i++) rnd_seq[i] = rnd_seq[0];
            end else begin
                for (int i = 0; i < 16; i++) rnd_seq[i] = 8'($urandom);
            end
            req_in = r;
            drive_bounds();
            predict(r, p_idx, p_val, p_cyc);
            run_serve($sformatf("rnd%0d", t), p_idx, p_val, p_cyc, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
